fifo_stream_reader: RTL and testbench

- Single-clock read-side drain engine for the AsyncFifo read port.
- Pops entries via the rd_en/rd_data/rd_empty contract, absorbs the FIFO's 1-cycle read latency, and presents the data as a valid/ready stream.
- Sits in the read clock domain between the FIFO and any downstream consumer.
- Its 2-entry skid buffer sustains 1 word/cycle with no bubbles and no data loss under backpressure.

---
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops the FIFO, absorbs its 1-cycle read latency and
// presents a valid/ready stream through a 2-entry skid buffer.
// Optional pop counter output enabled by defining FIFO_READER_COUNT_EN.
module fifo_stream_reader #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 32
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  input  logic                enable,
  output logic                fifo_rd_en,
  input  logic [BITS-1:0]     fifo_rd_data,
  input  logic                fifo_rd_empty,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BITS-1:0]     m_data
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [CNT_BITS-1:0] pop_count
`endif
);

  if (BITS < 1 || CNT_BITS < 1) begin : g_param_check
    $error("fifo_stream_reader: BITS and CNT_BITS must be at least 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t            occ;
  occ_t            occ_next;
  logic            inflight;
  logic [BITS-1:0] tail_q;
  logic            drain;
  logic [2:0]      credit_used;
  logic [1:0]      slot_after_drain;

  assign drain            = m_valid && m_ready;
  assign credit_used      = {1'b0, occ} + {2'b00, inflight} - {2'b00, drain};
  assign slot_after_drain = occ - {1'b0, drain};

  // The m_ready term lets a draining buffer re-issue a pop in the same cycle.
  assign fifo_rd_en = rd_rst_n && enable && !fifo_rd_empty && (credit_used < 3'd2);

  always_comb begin
    occ_next = occ;
    case ({inflight, drain})
      2'b10:   occ_next = occ_t'(occ + 2'd1);
      2'b01:   occ_next = occ_t'(occ - 2'd1);
      default: occ_next = occ;
    endcase
  end

  // m_data is the head slot; tail_q only holds a word while occ is FULL.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      occ      <= EMPTY;
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      tail_q   <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ_next;
      m_valid  <= (occ_next != EMPTY);
      if (drain && occ == FULL) begin
        m_data <= tail_q;
      end
      if (inflight) begin
        if (slot_after_drain == 2'd0) begin
          m_data <= fifo_rd_data;
        end else begin
          tail_q <= fifo_rd_data;
        end
      end
    end
  end

`ifdef FIFO_READER_COUNT_EN
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pop_count <= '0;
    end else if (fifo_rd_en) begin
      pop_count <= pop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO read port model.
// Counter checks run only when FIFO_READER_COUNT_EN is defined.
module tb_fifo_stream_reader;

  logic        rd_clk;
  logic        rd_rst_n;
  logic        enable;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
`ifdef FIFO_READER_COUNT_EN
  logic [3:0]  pop_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [32];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  logic underflow = 1'b0;
  int pops_mark;

  fifo_stream_reader #(.BITS(32), .CNT_BITS(4)) dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .enable        (enable),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
`ifdef FIFO_READER_COUNT_EN
    ,
    .pop_count     (pop_count)
`endif
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  // FIFO read side: 1-cycle read latency, flushed together with the reader.
  assign fifo_rd_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr       <= wr_ptr;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      if (fifo_rd_empty) underflow <= 1'b1;
      fifo_rd_data <= mem[rd_ptr % 32];
      rd_ptr       <= rd_ptr + 1;
      pops         <= pops + 1;
    end
  end

  task automatic push(input logic [31:0] d);
    mem[wr_ptr % 32] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable  = en;
    m_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rd_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rd_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick(2);

    // Reset values, and pop forced low while reset is held
    checkOutput("rst_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    push(32'hDEAD);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("rst_rd_en_forced", {31'b0, fifo_rd_en}, 32'd0);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    rd_rst_n = 1'b1;
    tick(1);

    // Stream without backpressure
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("s_rd_en_start", {31'b0, fifo_rd_en}, 32'd1);
    tick(1);
    checkOutput("s_valid_c1", {31'b0, m_valid}, 32'd0);
    tick(1);
    checkOutput("s_valid_c2", {31'b0, m_valid}, 32'd1);
    checkOutput("s_data_c2", m_data, 32'h11);
    tick(1);
    checkOutput("s_valid_c3", {31'b0, m_valid}, 32'd1);
    checkOutput("s_data_c3", m_data, 32'h22);
    tick(1);
    checkOutput("s_data_c4", m_data, 32'h33);
    checkOutput("s_rd_en_empty", {31'b0, fifo_rd_en}, 32'd0);
    tick(1);
    checkOutput("s_valid_c5", {31'b0, m_valid}, 32'd1);
    checkOutput("s_data_c5", m_data, 32'h44);
    tick(1);
    checkOutput("s_valid_c6", {31'b0, m_valid}, 32'd0);

    // Backpressure: two pops fill the skid buffer, then hold
    pops_mark = pops;
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    applyStimulus(1'b1, 1'b0);
    tick(6);
    checkOutput("bp_pops", pops - pops_mark, 32'd2);
    checkOutput("bp_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    checkOutput("bp_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("bp_data_hold", m_data, 32'h11);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("bp_rd_en_release", {31'b0, fifo_rd_en}, 32'd1);
    tick(1);
    checkOutput("bp_data_1", m_data, 32'h22);
    tick(1);
    checkOutput("bp_data_2", m_data, 32'h33);
    tick(1);
    checkOutput("bp_valid_3", {31'b0, m_valid}, 32'd1);
    checkOutput("bp_data_3", m_data, 32'h44);
    tick(1);
    checkOutput("bp_valid_end", {31'b0, m_valid}, 32'd0);
    checkOutput("bp_pops_total", pops - pops_mark, 32'd4);

    // Empty FIFO for 20 cycles
    for (int i = 0; i < 20; i++) begin
      checkOutput("empty_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      checkOutput("empty_valid", {31'b0, m_valid}, 32'd0);
      tick(1);
    end

    // Enable dropped right after a pop is issued
    pops_mark = pops;
    applyStimulus(1'b0, 1'b1);
    push(32'h88); push(32'h99);
    #1;
    checkOutput("en_off_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    tick(1);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("en_on_rd_en", {31'b0, fifo_rd_en}, 32'd1);
    tick(1);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("en_drop_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    tick(1);
    checkOutput("en_drop_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("en_drop_data", m_data, 32'h88);
    tick(1);
    checkOutput("en_drop_valid_end", {31'b0, m_valid}, 32'd0);
    tick(3);
    checkOutput("en_drop_pops", pops - pops_mark, 32'd1);

    // Async reset with a full buffer, then fresh data
    applyStimulus(1'b1, 1'b0);
    push(32'h55); push(32'h66);
    tick(4);
    checkOutput("ar_pre_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("ar_pre_data", m_data, 32'h99);
    #1;
    rd_rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("ar_data", m_data, 32'd0);
    checkOutput("ar_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    tick(2);
    rd_rst_n = 1'b1;
    push(32'hAA);
    applyStimulus(1'b1, 1'b1);
    tick(2);
    checkOutput("ar_fresh_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("ar_fresh_data", m_data, 32'hAA);
    tick(1);
    checkOutput("ar_fresh_end", {31'b0, m_valid}, 32'd0);

    // 17 pops after a clean reset
    applyStimulus(1'b0, 1'b1);
    rd_rst_n = 1'b0;
    tick(1);
    rd_rst_n = 1'b1;
    tick(1);
`ifdef FIFO_READER_COUNT_EN
    checkOutput("cnt_reset", {28'b0, pop_count}, 32'd0);
`endif
    pops_mark = pops;
    for (int i = 0; i < 17; i++) push(32'h100 + i);
    applyStimulus(1'b1, 1'b1);
    tick(2);
    checkOutput("cnt_first_data", m_data, 32'h100);
    tick(22);
    checkOutput("cnt_pops", pops - pops_mark, 32'd17);
    checkOutput("cnt_last_valid", {31'b0, m_valid}, 32'd0);
`ifdef FIFO_READER_COUNT_EN
    checkOutput("cnt_wrap", {28'b0, pop_count}, 32'd1);
`endif

    checkOutput("no_underflow", {31'b0, underflow}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
